// File: rtl/mac_seq.sv
// mac_seq: drives an external byte-wide MAC through a dot-product job and returns the 2*DATA_WIDTH sum.
// Optional feature: define MAC_SEQ_OVF_EN to enable the sticky result_ovf flag.
module mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    length,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic [DATA_WIDTH-1:0]   mac_data,
  output logic [3:0]              mac_opcode,
  input  logic [DATA_WIDTH-1:0]   mac_result,
  input  logic                    acc_overflow,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    result_ovf,
  output logic                    busy
);

  localparam logic [3:0] MAC_RESET = 4'h0;
  localparam logic [3:0] MAC_REGA  = 4'h1;
  localparam logic [3:0] MAC_REGB  = 4'h2;
  localparam logic [3:0] MAC_MULT  = 4'h3;
  localparam logic [3:0] MAC_ACC   = 4'h4;
  localparam logic [3:0] MAC_MSW   = 4'h5;
  localparam logic [3:0] MAC_LSW   = 4'h6;
  localparam logic [3:0] MAC_NOP   = 4'hF;

  typedef enum logic [3:0] {
    IDLE, CLR, FETCH, LDA, LDB, MUL, ACC, RDM, RDL, CAPL, DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [LEN_WIDTH-1:0]    w_rem_dec;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [3:0]              r_op;
  logic [3:0]              w_op;
  logic                    r_in_ready;
  logic                    r_res_valid;
  logic                    r_busy;
  logic [2*DATA_WIDTH-1:0] r_result;

  assign w_rem_dec = r_rem - LEN_WIDTH'(1);

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CLR;
      CLR:     w_next = (r_len != '0) ? FETCH : RDM;
      FETCH:   if (in_valid) w_next = LDA;
      LDA:     w_next = LDB;
      LDB:     w_next = MUL;
      MUL:     w_next = ACC;
      ACC:     w_next = (w_rem_dec != '0) ? FETCH : RDM;
      RDM:     w_next = RDL;
      RDL:     w_next = CAPL;
      CAPL:    w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    w_op = MAC_NOP;
    case (w_next)
      CLR:     w_op = MAC_RESET;
      LDA:     w_op = MAC_REGA;
      LDB:     w_op = MAC_REGB;
      MUL:     w_op = MAC_MULT;
      ACC:     w_op = MAC_ACC;
      RDM:     w_op = MAC_MSW;
      RDL:     w_op = MAC_LSW;
      default: w_op = MAC_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_rem       <= '0;
      r_b         <= '0;
      r_data      <= '0;
      r_op        <= MAC_NOP;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_next;
      r_op        <= w_op;
      r_in_ready  <= (w_next == FETCH);
      r_res_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
      // Operand a goes straight to mac_data on the handshake edge; only b needs holding for LDB.
      if (w_next == LDA)      r_data <= in_a;
      else if (w_next == LDB) r_data <= r_b;
      else                    r_data <= '0;

      case (r_state)
        IDLE: if (start) begin
          r_len <= length;
          r_rem <= '0;
        end
        CLR:   r_rem <= r_len;
        FETCH: if (in_valid) r_b <= in_b;
        ACC:   r_rem <= w_rem_dec;
        RDL:   r_result[2*DATA_WIDTH-1:DATA_WIDTH] <= mac_result;
        CAPL:  r_result[DATA_WIDTH-1:0] <= mac_result;
        default: ;
      endcase
    end
  end

`ifdef MAC_SEQ_OVF_EN
  logic r_ovf;
  logic w_ovf_win;

  // The MAC accumulator is stale during CLR, so sampling starts on the cycle after it.
  assign w_ovf_win = (r_state != IDLE) && (r_state != CLR) && (r_state != DONE);

  always_ff @(posedge clk) begin
    if (reset)                         r_ovf <= 1'b0;
    else if (r_state == IDLE && start) r_ovf <= 1'b0;
    else if (w_ovf_win && acc_overflow) r_ovf <= 1'b1;
  end

  assign result_ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = acc_overflow;
  assign result_ovf   = 1'b0;
`endif

  assign in_ready   = r_in_ready;
  assign res_valid  = r_res_valid;
  assign busy       = r_busy;
  assign result     = r_result;
  assign mac_data   = r_data;
  assign mac_opcode = r_op;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: self-checking bench for mac_seq with a behavioural MAC and a dot-product reference model.
module tb_mac_seq;
  localparam int DW = 8;
  localparam int LW = 8;

  localparam logic [3:0] MAC_RESET = 4'h0;
  localparam logic [3:0] MAC_REGA  = 4'h1;
  localparam logic [3:0] MAC_REGB  = 4'h2;
  localparam logic [3:0] MAC_MULT  = 4'h3;
  localparam logic [3:0] MAC_ACC   = 4'h4;
  localparam logic [3:0] MAC_MSW   = 4'h5;
  localparam logic [3:0] MAC_LSW   = 4'h6;
  localparam logic [3:0] MAC_NOP   = 4'hF;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [LW-1:0] length = '0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          in_ready, res_valid, result_ovf, busy, acc_overflow;
  logic [DW-1:0] mac_data, mac_result;
  logic [3:0]    mac_opcode;
  logic [2*DW-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_data(mac_data), .mac_opcode(mac_opcode), .mac_result(mac_result),
    .acc_overflow(acc_overflow), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .result_ovf(result_ovf), .busy(busy)
  );

  // Behavioural downstream MAC: one-cycle registered response to each opcode.
  logic [DW-1:0]   m_a = '0, m_b = '0, m_out = '0;
  logic [2*DW-1:0] m_prod = '0, m_acc = '0;
  always @(posedge clk) begin
    case (mac_opcode)
      MAC_RESET: begin m_a <= '0; m_b <= '0; m_prod <= '0; m_acc <= '0; end
      MAC_REGA:  m_a <= mac_data;
      MAC_REGB:  m_b <= mac_data;
      MAC_MULT:  m_prod <= (2*DW)'(m_a) * (2*DW)'(m_b);
      MAC_ACC:   m_acc <= m_acc + m_prod;
      MAC_MSW:   m_out <= m_acc[2*DW-1:DW];
      MAC_LSW:   m_out <= m_acc[DW-1:0];
      default: ;
    endcase
  end
  assign mac_result   = m_out;
  assign acc_overflow = m_acc[2*DW-1];

  logic [DW-1:0] ja [8];
  logic [DW-1:0] jb [8];
  int            jn;
  logic [3:0]    op_log [$];
  bit            rdy_log [$];

  function automatic void ref_model(output logic [2*DW-1:0] r, output logic o);
    int unsigned s = 0;
    o = 1'b0;
    for (int i = 0; i < jn; i++) begin
      s = s + int'(ja[i]) * int'(jb[i]);
      if (s[2*DW-1]) o = 1'b1;
    end
    r = s[2*DW-1:0];
`ifndef MAC_SEQ_OVF_EN
    o = 1'b0;
`endif
  endfunction

  task automatic do_job(input int stall0, input bit gaps, input bit hold,
                        output int lat, output bit tmo,
                        output logic [2*DW-1:0] res, output logic ovf);
    int idx = 0;
    int cyc;
    bit hs;
    op_log.delete(); rdy_log.delete();
    tmo = 1'b0; lat = 0; res = 'x; ovf = 1'bx;
    @(negedge clk);
    start = 1'b1; length = LW'(jn); in_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid) begin lat = cyc; res = result; ovf = result_ovf; break; end
      if (cyc > 5*jn + 300) begin tmo = 1'b1; break; end
      op_log.push_back(mac_opcode);
      rdy_log.push_back(in_ready);
      if (idx < jn && op_log.size() > 1 + stall0 && (!gaps || $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1; in_a = ja[idx]; in_b = jb[idx];
      end else begin
        in_valid = 1'b0; in_a = DW'($urandom); in_b = DW'($urandom);
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    if (!hold && !tmo) begin
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, res_valid, busy, result_ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/busy/ovf=%b want 0000", {in_ready, res_valid, busy, result_ovf});
    end
    checks++;
    if ({result, mac_data, mac_opcode} !== {16'h0000, 8'h00, MAC_NOP}) begin
      errors++;
      $display("FAIL reset_data: got result=%h data=%h op=%h want 0000 00 f", result, mac_data, mac_opcode);
    end
    reset = 1'b0;
  endtask

  task automatic test_spec_pairs;
    int lat; bit tmo; logic [2*DW-1:0] r; logic o;
    jn = 2; ja[0] = 3; jb[0] = 4; ja[1] = 5; jb[1] = 6;
    do_job(0, 1'b0, 1'b0, lat, tmo, r, o);
    checks++;
    if (tmo) begin errors++; $display("FAIL spec_timeout: res_valid never seen"); end
    checks++;
    if (r !== 16'h002A) begin errors++; $display("FAIL spec_result: got %h want 002a", r); end
    checks++;
    if (o !== 1'b0) begin errors++; $display("FAIL spec_ovf: got %b want 0", o); end
    checks++;
    if (lat != 15) begin errors++; $display("FAIL spec_latency: got %0d want 15", lat); end
  endtask

  task automatic test_overflow;
    int lat; bit tmo; logic [2*DW-1:0] r; logic o; logic eo;
`ifdef MAC_SEQ_OVF_EN
    eo = 1'b1;
`else
    eo = 1'b0;
`endif
    jn = 2; ja[0] = 255; jb[0] = 255; ja[1] = 255; jb[1] = 255;
    do_job(0, 1'b0, 1'b0, lat, tmo, r, o);
    checks++;
    if (r !== 16'hFC02) begin errors++; $display("FAIL ovf_result: got %h want fc02", r); end
    checks++;
    if (o !== eo) begin errors++; $display("FAIL ovf_flag: got %b want %b", o, eo); end
  endtask

  task automatic test_zero_len;
    int lat; bit tmo; logic [2*DW-1:0] r; logic o; bit seen_rdy;
    jn = 0;
    do_job(0, 1'b0, 1'b0, lat, tmo, r, o);
    checks++;
    if (op_log.size() != 4 || op_log[0] !== MAC_RESET || op_log[1] !== MAC_MSW ||
        op_log[2] !== MAC_LSW || op_log[3] !== MAC_NOP) begin
      errors++;
      $display("FAIL zero_opseq: got %0d ops %p want RESET,MSW,LSW,NOP", op_log.size(), op_log);
    end
    seen_rdy = 1'b0;
    foreach (rdy_log[i]) if (rdy_log[i]) seen_rdy = 1'b1;
    checks++;
    if (seen_rdy) begin errors++; $display("FAIL zero_in_ready: got in_ready high want never"); end
    checks++;
    if ({r, o} !== 17'h0) begin errors++; $display("FAIL zero_result: got %h ovf %b want 0000 0", r, o); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL zero_latency: got %0d want 5", lat); end
  endtask

  task automatic test_stall;
    int lat; bit tmo; logic [2*DW-1:0] r, er; logic o, eo;
    jn = 2;
    for (int i = 0; i < 2; i++) begin ja[i] = DW'($urandom); jb[i] = DW'($urandom); end
    ref_model(er, eo);
    do_job(3, 1'b0, 1'b0, lat, tmo, r, o);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (i >= op_log.size() || op_log[i] !== MAC_NOP || rdy_log[i] !== 1'b1) begin
        errors++;
        $display("FAIL stall_fetch%0d: op/rdy not NOP/1 while in_valid low", i);
      end
    end
    checks++;
    if (r !== er) begin errors++; $display("FAIL stall_result: got %h want %h", r, er); end
    checks++;
    if (lat != 18) begin errors++; $display("FAIL stall_latency: got %0d want 18", lat); end
  endtask

  task automatic test_done_hold;
    int lat; bit tmo; logic [2*DW-1:0] r, er; logic o, eo;
    jn = 3;
    for (int i = 0; i < 3; i++) begin ja[i] = DW'($urandom); jb[i] = DW'($urandom); end
    ref_model(er, eo);
    do_job(0, 1'b0, 1'b1, lat, tmo, r, o);
    checks++;
    if (r !== er || o !== eo) begin errors++; $display("FAIL hold_result: got %h/%b want %h/%b", r, o, er, eo); end
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      length = LW'($urandom_range(0, 5));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({res_valid, busy, result, result_ovf} !== {1'b1, 1'b1, er, eo}) begin
        errors++;
        $display("FAIL hold_stable%0d: got vld=%b busy=%b res=%h ovf=%b want 1 1 %h %b",
                 k, res_valid, busy, result, result_ovf, er, eo);
      end
    end
    start = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL hold_release: got busy/vld=%b want 00 (same-cycle start ignored)", {busy, res_valid});
    end
  endtask

  task automatic test_mid_reset;
    int lat; bit tmo; logic [2*DW-1:0] r; logic o; bit found = 1'b0;
    @(negedge clk);
    start = 1'b1; length = 8'd2; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mac_opcode === MAC_REGB) found = 1'b1;
      else begin @(posedge clk); @(negedge clk); end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_ldb: got no MAC_REGB want one within 20 cycles"); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, res_valid, busy, result_ovf, result, mac_data, mac_opcode} !==
        {4'b0000, 16'h0000, 8'h00, MAC_NOP}) begin
      errors++;
      $display("FAIL midrst_values: got rdy/vld/busy/ovf=%b res=%h data=%h op=%h want 0000 0000 00 f",
               {in_ready, res_valid, busy, result_ovf}, result, mac_data, mac_opcode);
    end
    jn = 1; ja[0] = 2; jb[0] = 7;
    do_job(0, 1'b0, 1'b0, lat, tmo, r, o);
    checks++;
    if (r !== 16'h000E || o !== 1'b0) begin errors++; $display("FAIL midrst_next: got %h/%b want 000e/0", r, o); end
  endtask

  task automatic test_random;
    int lat; bit tmo; bit gaps; logic [2*DW-1:0] r, er; logic o, eo;
    for (int t = 0; t < 25; t++) begin
      jn = $urandom_range(0, 6);
      gaps = 1'($urandom_range(0, 1));
      for (int i = 0; i < jn; i++) begin ja[i] = DW'($urandom); jb[i] = DW'($urandom); end
      ref_model(er, eo);
      do_job(0, gaps, 1'b0, lat, tmo, r, o);
      checks++;
      if (tmo || r !== er || o !== eo) begin
        errors++;
        $display("FAIL rand%0d_result: n=%0d got %h/%b want %h/%b tmo=%b", t, jn, r, o, er, eo, tmo);
      end
      if (!gaps) begin
        checks++;
        if (lat != 5*jn + 5) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, 5*jn + 5); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_pairs();
    test_overflow();
    test_zero_len();
    test_stall();
    test_done_hold();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
